// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: two-port arbiter for a combinational instruction memory with 1-cycle registered responses.
// Ports: Clk/Rst_n (async active-low reset); Req0/Req1, Addr0/Addr1 request inputs;
// Gnt0/Gnt1 combinational grants; RspValid0/RspValid1, RspData, RspErr registered response;
// RrEn selects round-robin (1) or fixed priority to port 0 (0); Stall blocks new grants;
// MemAddr/MemRdata connect to the combinational memory.
module imem_fetch_arbiter #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 512
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [31:0]       Addr0,
    input  logic [31:0]       Addr1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              RspValid0,
    output logic              RspValid1,
    output logic [DATA_W-1:0] RspData,
    output logic              RspErr,
    input  logic              RrEn,
    input  logic              Stall,
    output logic [31:0]       MemAddr,
    input  logic [DATA_W-1:0] MemRdata
);
    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                ready_q;
    logic [31:0]         mem_addr_q;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_v0_q, rsp_v1_q;
    logic                win0, any_gnt, err;
    logic [31:0]         gnt_addr;
    // ready_q keeps grants off until the first rising edge after reset release;
    // last_q=1 means port 1 was granted last, so port 0 wins the next conflict
    assign win0     = Req0 & (~RrEn | ~Req1 | last_q);
    assign Gnt0     = ready_q & ~Stall & win0;
    assign Gnt1     = ready_q & ~Stall & Req1 & ~win0;
    assign any_gnt  = Gnt0 | Gnt1;
    assign gnt_addr = Gnt1 ? Addr1 : Addr0;
    assign MemAddr  = any_gnt ? gnt_addr : mem_addr_q;
    // word index compared at full 32-bit width so 0xFFFFFFFC cannot wrap into range
    assign err      = (|gnt_addr[1:0]) | ({2'b00, gnt_addr[31:2]} >= DEPTH_L);
    assign RspData   = rsp_data_q;
    assign RspErr    = rsp_err_q;
    assign RspValid0 = rsp_v0_q;
    assign RspValid1 = rsp_v1_q;
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (any_gnt) begin
            last_d     = Gnt1;
            rsp_data_d = err ? '0 : MemRdata;
            rsp_err_d  = err;
        end
        if (Stall)
            state_d = HOLD;
        else if (state_q == HOLD)
            state_d = IDLE;
        else
            state_d = any_gnt ? RESP : IDLE;
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            ready_q    <= 1'b0;
            mem_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_v0_q   <= 1'b0;
            rsp_v1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            ready_q    <= 1'b1;
            mem_addr_q <= MemAddr;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_v0_q   <= Gnt0;
            rsp_v1_q   <= Gnt1;
        end
    end
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: directed scoreboard bench for imem_fetch_arbiter.
module tb_imem_fetch_arbiter;
    logic        Clk = 1'b0;
    logic        Rst_n, Req0, Req1, RrEn, Stall;
    logic [31:0] Addr0, Addr1, MemAddr, MemRdata, RspData;
    logic        Gnt0, Gnt1, RspValid0, RspValid1, RspErr;
    typedef struct {logic port; logic [31:0] data; logic err;} rsp_t;
    rsp_t        sb[$];
    logic [31:0] exp_addr;
    int          tests = 0;
    int          fails = 0;
    always #5 Clk = ~Clk;
    imem_fetch_arbiter #(.DATA_W(32), .DEPTH_WORDS(512)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req0(Req0), .Req1(Req1), .Addr0(Addr0), .Addr1(Addr1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RspValid0(RspValid0), .RspValid1(RspValid1),
        .RspData(RspData), .RspErr(RspErr), .RrEn(RrEn), .Stall(Stall),
        .MemAddr(MemAddr), .MemRdata(MemRdata)
    );
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a[31:2] == 30'd4) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) | 32'h1);
    endfunction
    function automatic logic is_err(input logic [31:0] a);
        return (a % 4 != 0) || (64'(a) >= 64'd2048);
    endfunction
    assign MemRdata = mem_f(MemAddr);
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input logic g0, input logic g1);
        rsp_t r;
        logic [31:0] a;
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("rsp_valid0", 32'(RspValid0), 32'(r.port == 1'b0));
            chk("rsp_valid1", 32'(RspValid1), 32'(r.port == 1'b1));
            chk("rsp_data", RspData, r.data);
            chk("rsp_err", 32'(RspErr), 32'(r.err));
        end else begin
            chk("no_valid0", 32'(RspValid0), 32'd0);
            chk("no_valid1", 32'(RspValid1), 32'd0);
        end
        chk("gnt0", 32'(Gnt0), 32'(g0));
        chk("gnt1", 32'(Gnt1), 32'(g1));
        if (g0 | g1) begin
            a = g0 ? Addr0 : Addr1;
            exp_addr = a;
            r.port = g1;
            r.err  = is_err(a);
            r.data = r.err ? 32'd0 : mem_f(a);
            sb.push_back(r);
        end
        chk("mem_addr", MemAddr, exp_addr);
        @(negedge Clk);
    endtask
    initial begin
        Rst_n = 1'b0; Req0 = 1'b1; Req1 = 1'b1; RrEn = 1'b1; Stall = 1'b0;
        Addr0 = 32'h20; Addr1 = 32'h40; exp_addr = 32'h0;
        #2;
        chk("rst_gnt0", 32'(Gnt0), 32'd0);
        chk("rst_gnt1", 32'(Gnt1), 32'd0);
        chk("rst_valid", {30'd0, RspValid1, RspValid0}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_data", RspData, 32'd0);
        chk("rst_err", 32'(RspErr), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        cyc(0, 0);
        Req0 = 1'b1; Req1 = 1'b1;
        cyc(1, 0); cyc(0, 1); cyc(1, 0); cyc(0, 1);
        Req0 = 1'b0; Req1 = 1'b0;
        cyc(0, 0);
        Req0 = 1'b1; Addr0 = 32'h10;
        cyc(1, 0);
        Req0 = 1'b0;
        cyc(0, 0);
        Req1 = 1'b1; Addr1 = 32'h7FC;
        cyc(0, 1);
        Req1 = 1'b0;
        cyc(0, 0);
        RrEn = 1'b0; Req0 = 1'b1; Req1 = 1'b1; Addr0 = 32'h24; Addr1 = 32'h44;
        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        Req0 = 1'b0;
        cyc(0, 1);
        Req1 = 1'b0;
        cyc(0, 0);
        Req1 = 1'b1; Addr1 = 32'h6;
        cyc(0, 1);
        Addr1 = 32'h800;
        cyc(0, 1);
        Addr1 = 32'hFFFFFFFC;
        cyc(0, 1);
        Req1 = 1'b0;
        cyc(0, 0);
        Req0 = 1'b1; Addr0 = 32'h8;
        cyc(1, 0);
        Stall = 1'b1; Addr0 = 32'hC;
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        Stall = 1'b0;
        cyc(1, 0);
        Req0 = 1'b0;
        cyc(0, 0);
        RrEn = 1'b1; Req0 = 1'b1; Req1 = 1'b1; Addr0 = 32'h50; Addr1 = 32'h60;
        cyc(0, 1);
        RrEn = 1'b0;
        cyc(1, 0);
        RrEn = 1'b1;
        cyc(0, 1);
        Req0 = 1'b0; Req1 = 1'b0;
        cyc(0, 0);
        Stall = 1'b1; Req1 = 1'b1;
        cyc(0, 0);
        Stall = 1'b0; Req1 = 1'b0;
        cyc(0, 0);
        Req0 = 1'b1; Addr0 = 32'h14;
        cyc(1, 0);
        Req0 = 1'b0;
        cyc(0, 0);
        Req1 = 1'b1; Addr1 = 32'h30;
        #1;
        chk("pre_rst_gnt1", 32'(Gnt1), 32'd1);
        Rst_n = 1'b0; Req1 = 1'b0;
        #1;
        chk("mid_rst_gnt", {30'd0, Gnt1, Gnt0}, 32'd0);
        chk("mid_rst_valid", {30'd0, RspValid1, RspValid0}, 32'd0);
        chk("mid_rst_memaddr", MemAddr, 32'd0);
        chk("mid_rst_data", RspData, 32'd0);
        chk("mid_rst_err", 32'(RspErr), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1; exp_addr = 32'h0; sb.delete();
        cyc(0, 0);
        Req0 = 1'b1; Req1 = 1'b1; Addr0 = 32'h18; Addr1 = 32'h1C;
        cyc(1, 0);
        Req0 = 1'b0; Req1 = 1'b0;
        cyc(0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
